sram_like_mem: RTL and testbench

Parametrised SRAM-like slave memory model. It serves one sram-like channel (req/wr/size/addr/wdata, addr_ok/data_ok/rdata) for the instruction or data port of the mips core in simulation benches. It adds the following over a fixed single-cycle model:
- configurable read/write data latency
- multiple outstanding requests, returned in order
- pseudo-random addr_ok back-pressure
- byte/half/word write merging
- a write-observe port for answer-file checking

---
 rtl/sram_like_pkg.sv | 56 +++++
 rtl/sram_like_resp_fifo.sv | 71 +++++++
 rtl/sram_like_mem.sv | 113 +++++++++++
 tb/tb_sram_like_mem.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_pkg.sv
// Shared types and helpers for the SRAM-like slave memory model:
// transfer sizes, lane enables, write merging and the stall LFSR.
package sram_like_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Half needs addr[0]=0, word needs addr[1:0]=0; size 3 behaves as a word.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = a[0];
      default: bad = (a != 2'b00);
    endcase
    return bad;
  endfunction

  // Lane enables for a MIPS-style lane-aligned store; misaligned accesses enable nothing.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] be;
    if (misaligned(size, a)) begin
      be = 4'b0000;
    end else begin
      case (size)
        SZ_BYTE: be = 4'b0001 << a;
        SZ_HALF: be = a[1] ? 4'b1100 : 4'b0011;
        default: be = 4'b1111;
      endcase
    end
    return be;
  endfunction

  // Replace the enabled byte lanes of the old word with the matching lanes of wdata.
  function automatic logic [31:0] merge(input logic [31:0] old_word,
                                        input logic [31:0] wdata,
                                        input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? wdata[8*i +: 8] : old_word[8*i +: 8];
    end
    return res;
  endfunction

  // One step of the stall LFSR.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/sram_like_resp_fifo.sv
// In-order response queue. Each entry carries a payload and a countdown
// that ages every cycle; the head is ready once its countdown reaches zero.
module sram_like_resp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  parameter int CD_W  = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic [CD_W-1:0]  push_cd,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_ready,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [CD_W-1:0]  cd_q   [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign do_push    = push && (count != FULL_CNT);
  assign do_pop     = pop && (count != '0);
  assign head_data  = data_q[rd_ptr];
  assign head_ready = (count != '0) && (cd_q[rd_ptr] == '0);

  // Pointer and occupancy bookkeeping; reset discards every queued entry.
  // NOTE: sequential state uses non-blocking assignment so all flops see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage: load on push, otherwise age the countdown toward zero.
  // NOTE: storage is not reset; occupancy alone decides which slots are meaningful.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (do_push && (wr_ptr == PTR_W'(i))) begin
        data_q[i] <= push_data;
        cd_q[i]   <= push_cd;
      end else if (cd_q[i] != '0) begin
        cd_q[i] <= cd_q[i] - 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_like_mem.sv
// SRAM-like slave memory model: word array with byte-lane writes, in-order
// responses after a fixed latency, bounded outstanding requests and
// LFSR-driven addr_ok back-pressure. The array is reachable as `mem`.
module sram_like_mem
  import sram_like_pkg::*;
#(
  parameter int          DEPTH_WORDS     = 4096,
  parameter int          DATA_LATENCY    = 1,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [15:0] STALL_MASK      = 16'h0000,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1,
  parameter bit          CHECK_ALIGN     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic        wr_fire,
  output logic [31:0] wr_addr,
  output logic [1:0]  wr_size,
  output logic [31:0] wr_merged,
  output logic        busy
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CD_W  = 4;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [31:0]      mem [DEPTH_WORDS];
  logic [15:0]      lfsr;
  logic             stall;
  logic             accept;
  logic [IDX_W-1:0] idx;
  logic [3:0]       be;
  logic [31:0]      old_word;
  logic [31:0]      merged;
  logic [CNT_W-1:0] fifo_count;
  logic [31:0]      head_data;
  logic             head_ready;

  // Higher address bits alias onto the array; bits [1:0] only pick lanes.
  assign idx    = addr[IDX_W+1:2];
  assign stall  = |(lfsr & STALL_MASK);
  // Held off during reset so no write can slip into the array before release.
  assign addr_ok = rst && (fifo_count < MAX_CNT) && !stall;
  assign accept  = req && addr_ok;

  // Decode the request and build the post-merge word from the pre-edge array.
  always_comb begin
    be       = byte_en(size, addr[1:0]);
    old_word = mem[idx];
    merged   = merge(old_word, wdata, be);
  end

  assign wr_fire   = accept && wr;
  assign wr_addr   = addr;
  assign wr_size   = size;
  assign wr_merged = merged;

  // Commit writes at the accepting edge; a read in the same cycle already captured old_word.
  always_ff @(posedge clk) begin
    if (accept && wr) mem[idx] <= merged;
  end

  // Stall LFSR free-runs every cycle out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= LFSR_SEED;
    else      lfsr <= lfsr_next(lfsr);
  end

  sram_like_resp_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (32),
    .CD_W  (CD_W),
    .CNT_W (CNT_W)
  ) u_resp_fifo (
    .clk        (clk),
    .rst_n      (rst),
    .push       (accept),
    .push_data  (wr ? merged : old_word),
    .push_cd    (CD_W'(DATA_LATENCY - 1)),
    .pop        (data_ok),
    .head_data  (head_data),
    .head_ready (head_ready),
    .count      (fifo_count)
  );

  assign data_ok = head_ready;
  assign busy    = (fifo_count != '0);

  // Read data is only driven while a response is retiring.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rdata = '0;
    if (data_ok) rdata = head_data;
  end

  // Flag misaligned half/word accesses in simulation; the access itself still completes.
  if (CHECK_ALIGN) begin : g_align_chk
    always_ff @(posedge clk) begin
      assert (!(rst && accept && misaligned(size, addr[1:0])))
        else $error("sram_like_mem: misaligned access size=%0d addr=%08h", size, addr);
    end
  end

endmodule

// File: tb/tb_sram_like_mem.sv
// Directed bench for sram_like_mem: five instances with different parameter
// sets, each driven through a shared request/response runner.
module tb_sram_like_mem;

  localparam int          N_DUT         = 5;
  localparam logic [15:0] TB_STALL_MASK = 16'h0001;
  localparam logic [15:0] TB_SEED       = 16'hACE1;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } tb_req_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } tb_exp_t;

  logic        clk = 1'b0;
  logic        rst     [N_DUT];
  logic        req     [N_DUT];
  logic        wr      [N_DUT];
  logic [1:0]  size    [N_DUT];
  logic [31:0] addr    [N_DUT];
  logic [31:0] wdata   [N_DUT];
  logic [31:0] rdata   [N_DUT];
  logic        addr_ok [N_DUT];
  logic        data_ok [N_DUT];
  logic        wr_fire [N_DUT];
  logic [31:0] wr_addr [N_DUT];
  logic [1:0]  wr_size [N_DUT];
  logic [31:0] wr_merged [N_DUT];
  logic        busy    [N_DUT];

  int      n_checks = 0;
  int      n_fail   = 0;
  tb_req_t rq [$];
  tb_exp_t eq [$];
  int      acc_log [$];

  always #5 clk = ~clk;

  // 0: defaults
  sram_like_mem u_d0 (
    .clk(clk), .rst(rst[0]), .req(req[0]), .wr(wr[0]), .size(size[0]), .addr(addr[0]),
    .wdata(wdata[0]), .rdata(rdata[0]), .addr_ok(addr_ok[0]), .data_ok(data_ok[0]),
    .wr_fire(wr_fire[0]), .wr_addr(wr_addr[0]), .wr_size(wr_size[0]),
    .wr_merged(wr_merged[0]), .busy(busy[0]));

  // 1: latency 3, two outstanding
  sram_like_mem #(.DATA_LATENCY(3), .MAX_OUTSTANDING(2)) u_d1 (
    .clk(clk), .rst(rst[1]), .req(req[1]), .wr(wr[1]), .size(size[1]), .addr(addr[1]),
    .wdata(wdata[1]), .rdata(rdata[1]), .addr_ok(addr_ok[1]), .data_ok(data_ok[1]),
    .wr_fire(wr_fire[1]), .wr_addr(wr_addr[1]), .wr_size(wr_size[1]),
    .wr_merged(wr_merged[1]), .busy(busy[1]));

  // 2: pseudo-random back-pressure
  sram_like_mem #(.STALL_MASK(TB_STALL_MASK), .LFSR_SEED(TB_SEED)) u_d2 (
    .clk(clk), .rst(rst[2]), .req(req[2]), .wr(wr[2]), .size(size[2]), .addr(addr[2]),
    .wdata(wdata[2]), .rdata(rdata[2]), .addr_ok(addr_ok[2]), .data_ok(data_ok[2]),
    .wr_fire(wr_fire[2]), .wr_addr(wr_addr[2]), .wr_size(wr_size[2]),
    .wr_merged(wr_merged[2]), .busy(busy[2]));

  // 3: latency 4, used for reset while requests are in flight
  sram_like_mem #(.DATA_LATENCY(4)) u_d3 (
    .clk(clk), .rst(rst[3]), .req(req[3]), .wr(wr[3]), .size(size[3]), .addr(addr[3]),
    .wdata(wdata[3]), .rdata(rdata[3]), .addr_ok(addr_ok[3]), .data_ok(data_ok[3]),
    .wr_fire(wr_fire[3]), .wr_addr(wr_addr[3]), .wr_size(wr_size[3]),
    .wr_merged(wr_merged[3]), .busy(busy[3]));

  // 4: tiny array to exercise aliasing and a deliberate misaligned store
  sram_like_mem #(.DEPTH_WORDS(16), .CHECK_ALIGN(1'b0)) u_d4 (
    .clk(clk), .rst(rst[4]), .req(req[4]), .wr(wr[4]), .size(size[4]), .addr(addr[4]),
    .wdata(wdata[4]), .rdata(rdata[4]), .addr_ok(addr_ok[4]), .data_ok(data_ok[4]),
    .wr_fire(wr_fire[4]), .wr_addr(wr_addr[4]), .wr_size(wr_size[4]),
    .wr_merged(wr_merged[4]), .busy(busy[4]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic add(input logic w, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] e);
    tb_req_t r;
    r.wr = w; r.size = sz; r.addr = a; r.wdata = d; r.exp = e;
    rq.push_back(r);
  endtask

  function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // Drive the queued requests into instance k (req held while any remain and
  // cyc < hold, hold=0 meaning no limit), check every response in order and
  // its arrival cycle, and return the number of cycles req waited on addr_ok.
  task automatic run(input int k, input int lat, input int hold, input int budget,
                     output int low_cnt);
    int      cyc;
    bit      issuing;
    bit      done;
    tb_req_t r;
    tb_exp_t e;
    cyc = 0; low_cnt = 0; done = 1'b0;
    acc_log.delete();
    eq.delete();
    while (!done && cyc < budget) begin
      issuing = (rq.size() != 0) && (hold == 0 || cyc < hold);
      req[k] = issuing;
      if (issuing) begin
        wr[k] = rq[0].wr; size[k] = rq[0].size; addr[k] = rq[0].addr; wdata[k] = rq[0].wdata;
      end
      @(negedge clk);
      if (data_ok[k]) begin
        if (eq.size() == 0) begin
          check("spurious_data_ok", 32'(data_ok[k]), 32'd0);
        end else begin
          e = eq.pop_front();
          check("rdata", rdata[k], e.data);
          check("data_ok_cycle", 32'(cyc), 32'(e.due));
        end
      end
      if (issuing) begin
        if (addr_ok[k]) begin
          r = rq.pop_front();
          acc_log.push_back(cyc);
          eq.push_back('{data: r.exp, due: cyc + lat});
          check("wr_fire", 32'(wr_fire[k]), 32'(r.wr));
          if (r.wr) begin
            check("wr_merged", wr_merged[k], r.exp);
            check("wr_addr", wr_addr[k], r.addr);
          end
        end else begin
          low_cnt++;
        end
      end
      done = !issuing && (eq.size() == 0);
      @(posedge clk); #1;
      cyc++;
    end
    req[k] = 1'b0;
    check("run_completed", 32'(done), 32'd1);
    rq.delete();
  endtask

  task automatic pulse_reset(input int k);
    @(posedge clk); #1;
    rst[k] = 1'b0;
    @(posedge clk); #1;
    rst[k] = 1'b1;
  endtask

  initial begin
    int          low;
    int          exp_low;
    int          highs;
    logic [15:0] m;

    for (int k = 0; k < N_DUT; k++) begin
      rst[k] = 1'b0; req[k] = 1'b0; wr[k] = 1'b0; size[k] = 2'd2;
      addr[k] = '0; wdata[k] = '0;
    end
    // Preload while held in reset; the arrays keep their contents across reset.
    u_d0.mem[16] = 32'hAABBCCDD;
    for (int i = 0; i < 3; i++)   u_d1.mem[i] = 32'h0B0B0000 + 32'(i);
    for (int i = 0; i < 250; i++) u_d2.mem[i] = 32'h5A000000 + 32'(i);
    u_d3.mem[4] = 32'hCAFE0004;
    u_d3.mem[5] = 32'hCAFE0005;
    u_d4.mem[0] = 32'hDEADBEEF;

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < N_DUT; k++) begin
      check($sformatf("rst_data_ok_%0d", k), 32'(data_ok[k]), 32'd0);
      check($sformatf("rst_rdata_%0d", k),   rdata[k], 32'd0);
      check($sformatf("rst_busy_%0d", k),    32'(busy[k]), 32'd0);
      check($sformatf("rst_wr_fire_%0d", k), 32'(wr_fire[k]), 32'd0);
    end
    for (int k = 0; k < N_DUT; k++) rst[k] = 1'b1;
    @(negedge clk);
    check("idle_addr_ok", 32'(addr_ok[0]), 32'd1);
    @(posedge clk); #1;

    // Word store/load, then byte and half merges onto a preloaded word.
    add(1'b1, 2'd2, 32'h100, 32'h11223344, 32'h11223344);
    add(1'b0, 2'd2, 32'h100, 32'h0,        32'h11223344);
    add(1'b1, 2'd0, 32'h41,  32'h0000EE00, 32'hAABBEEDD);
    add(1'b1, 2'd1, 32'h42,  32'h12340000, 32'h1234EEDD);
    add(1'b0, 2'd2, 32'h40,  32'h0,        32'h1234EEDD);
    run(0, 1, 0, 50, low);
    check("default_no_stall", 32'(low), 32'd0);

    // Latency 3 with two outstanding: third read waits for the first retirement.
    for (int i = 0; i < 3; i++) add(1'b0, 2'd2, 32'(4 * i), 32'h0, 32'h0B0B0000 + 32'(i));
    run(1, 3, 0, 50, low);
    check("lat3_accepts", 32'(acc_log.size()), 32'd3);
    if (acc_log.size() == 3) begin
      check("lat3_acc0", 32'(acc_log[0]), 32'd0);
      check("lat3_acc1", 32'(acc_log[1]), 32'd1);
      check("lat3_acc2", 32'(acc_log[2]), 32'd4);
    end
    check("lat3_wait_cycles", 32'(low), 32'd2);

    // Back-pressure: req held 200 cycles from a fresh reset; compare stalls to the reference LFSR.
    pulse_reset(2);
    m = TB_SEED;
    exp_low = 0;
    for (int i = 0; i < 200; i++) begin
      if ((m & TB_STALL_MASK) != 16'h0) exp_low++;
      m = ref_lfsr(m);
    end
    for (int i = 0; i < 250; i++) add(1'b0, 2'd2, 32'(4 * i), 32'h0, 32'h5A000000 + 32'(i));
    run(2, 1, 200, 400, low);
    check("stall_low_cycles", 32'(low), 32'(exp_low));
    check("stall_accepts", 32'(acc_log.size()), 32'(200 - exp_low));

    // Reset with two reads in flight: they must never be answered.
    req[3] = 1'b1; wr[3] = 1'b0; size[3] = 2'd2; addr[3] = 32'h10;
    @(negedge clk);
    check("inflight_acc0", 32'(addr_ok[3]), 32'd1);
    @(posedge clk); #1;
    addr[3] = 32'h14;
    @(negedge clk);
    check("inflight_acc1", 32'(addr_ok[3]), 32'd1);
    @(posedge clk); #1;
    req[3] = 1'b0;
    @(negedge clk);
    check("inflight_busy", 32'(busy[3]), 32'd1);
    check("inflight_no_data", 32'(data_ok[3]), 32'd0);
    @(posedge clk); #1;
    rst[3] = 1'b0;
    #1;
    check("abort_busy", 32'(busy[3]), 32'd0);
    check("abort_data_ok", 32'(data_ok[3]), 32'd0);
    check("abort_rdata", rdata[3], 32'd0);
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin
        @(posedge clk); #1;
        rst[3] = 1'b1;
      end
      @(negedge clk);
      if (data_ok[3]) highs++;
    end
    check("abort_never_answered", 32'(highs), 32'd0);
    check("abort_mem4", u_d3.mem[4], 32'hCAFE0004);
    check("abort_mem5", u_d3.mem[5], 32'hCAFE0005);
    @(posedge clk); #1;
    add(1'b0, 2'd2, 32'h14, 32'h0, 32'hCAFE0005);
    run(3, 4, 0, 50, low);

    // 16-word array: 0x40 aliases word 0; misaligned half store changes nothing.
    add(1'b1, 2'd2, 32'h40, 32'h00000005, 32'h00000005);
    add(1'b0, 2'd2, 32'h00, 32'h0,        32'h00000005);
    add(1'b1, 2'd1, 32'h01, 32'hFFFFFFFF, 32'h00000005);
    add(1'b0, 2'd2, 32'h00, 32'h0,        32'h00000005);
    run(4, 1, 0, 50, low);
    check("alias_mem0", u_d4.mem[0], 32'h00000005);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
